// File: rtl/nibble_serial_sequencer.sv
// nibble_serial_sequencer
// Adds two NIBBLES*4-bit operands one nibble per cycle through an external
// combinational 4-bit adder, rippling the carry through a local register.
// Optional build macro SUB_MODE_EN adds an in_sub input that turns the
// operation into A - B (B inverted, carry forced to 1 at capture).
module nibble_serial_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
`ifdef SUB_MODE_EN
  input  logic                   in_sub,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             sub_sel;
  logic             idx_last;

`ifdef SUB_MODE_EN
  assign sub_sel = in_sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign idx_last = (idx_q == IDX_LAST);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, step nibbles in RUN, hand off in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; adder inputs are quiet outside RUN.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[idx_q*4 +: 4];
      add_b   = b_q[idx_q*4 +: 4];
      add_cin = carry_q;
    end
  end

  // Datapath next state: capture operands, then fold in one adder nibble per cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d    = in_a;
          idx_d  = '0;
          // Clear the previous result so no stale nibbles show while running.
          sum_d  = '0;
          cout_d = 1'b0;
          if (sub_sel) begin
            b_d     = ~in_b;
            carry_d = 1'b1;
          end else begin
            b_d     = in_b;
            carry_d = in_cin;
          end
        end
      end
      RUN: begin
        sum_d[idx_q*4 +: 4] = add_sum;
        carry_d             = add_cout;
        if (idx_last) begin
          idx_d  = '0;
          cout_d = add_cout;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_sequencer.sv
// Directed bench for nibble_serial_sequencer (NIBBLES = 4) with a behavioural
// 4-bit adder closing the loop on add_a/add_b/add_cin.
module tb_nibble_serial_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef SUB_MODE_EN
  logic         in_sub;
`endif
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int n_cmp;
  int n_err;

  nibble_serial_sequencer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SUB_MODE_EN
    .in_sub    (in_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  // External 4-bit adder.
  logic [4:0] adder_res;
  assign adder_res = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign add_sum   = adder_res[3:0];
  assign add_cout  = adder_res[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set, check latency and result, then accept it.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat;
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    tick();
    in_valid = 1'b0;
    chk({tag, "_cleared"}, 32'(out_sum), 32'd0);
    chk({tag, "_add_a0"}, 32'(add_a), 32'(a[3:0]));
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(N));
    chk({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'({busy, out_valid, in_ready}), 32'b001);
  endtask

  initial begin
    int cnt;
    bit seen_idle;
    bit seen_valid;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
`ifdef SUB_MODE_EN
    in_sub    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", 32'({busy, out_valid, in_ready}), 32'b001);
    chk("rst_sum", 32'({out_cout, out_sum}), 32'd0);
    chk("rst_adder", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic add and a full carry ripple.
    do_op("add1234", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op("cin1", 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0);

    // Result held while out_ready is low; in_valid meanwhile is ignored.
    in_valid = 1'b1;
    in_a     = 16'hA5A5;
    in_b     = 16'h1111;
    in_cin   = 1'b0;
    tick();
    in_a     = 16'h0F0F;
    in_b     = 16'h0101;
    chk("run_adder_cin", 32'(add_cin), 32'd0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'hB6B6);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_exit", 32'({busy, out_valid, in_ready}), 32'b001);

    // Reset while idx == 2 aborts the operation.
    in_valid = 1'b1;
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_partial", 32'(out_sum), 32'h0033);
    chk("pre_rst_add_a", 32'(add_a), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'({out_cout, out_sum}), 32'd0);
    chk("abort_flags", 32'({busy, out_valid, in_ready}), 32'b001);
    chk("abort_adder", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid || busy) seen_valid = 1'b1;
    end
    chk("abort_no_valid", 32'(seen_valid), 32'd0);
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

`ifdef SUB_MODE_EN
    in_sub = 1'b1;
    do_op("sub5m7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    do_op("sub7m5", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    in_sub = 1'b0;
`endif

    // Back-to-back: one IDLE cycle between results, N+2 cycles per result.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'h0001;
    in_b      = 16'h0002;
    in_cin    = 1'b0;
    tick();
    chk("b2b_first_busy", 32'(busy), 32'd1);
    cnt       = 0;
    seen_idle = 1'b0;
    while (cnt < 20) begin
      tick();
      cnt++;
      if (out_valid) chk("b2b_sum", 32'(out_sum), 32'h0003);
      if (in_ready) seen_idle = 1'b1;
      else if (seen_idle) break;
    end
    chk("b2b_period", 32'(cnt), 32'(N + 2));
    in_valid = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      tick();
      cnt++;
    end
    out_ready = 1'b0;
    chk("b2b_drain", 32'({busy, in_ready}), 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
